// File: rtl/tamrin_3_pkg.sv
// Shared constants and types for the tamrin_3 Boolean function cell.
package tamrin_3_pkg;

    localparam int unsigned MINTERM_W   = 3;
    localparam int unsigned N_MINTERMS  = 8;

    // Default function: 2:1 mux, f = x1 ? x2 : x3.
    localparam logic [N_MINTERMS-1:0] TAMRIN3_TT_DEFAULT = 8'hCA;

    typedef logic [MINTERM_W-1:0] minterm_t;

    function automatic minterm_t minterm_idx(input logic a, input logic b, input logic c);
        return minterm_t'({a, b, c});
    endfunction

endpackage

// File: rtl/tamrin_3.sv
// Three-input truth-table lookup with a registered copy of the result and
// a sticky record of which minterms have been sampled.
module tamrin_3
    import tamrin_3_pkg::*;
#(
    parameter logic [N_MINTERMS-1:0] TRUTH_TABLE = TAMRIN3_TT_DEFAULT,
    parameter logic                  RESET_F     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  x1,
    input  logic                  x2,
    input  logic                  x3,
    input  logic                  clr_seen,
    output logic                  f,
    output logic                  f_q,
    output logic [N_MINTERMS-1:0] seen,
    output logic                  all_seen
);

    minterm_t              w_idx;
    logic                  r_f_q;
    logic [N_MINTERMS-1:0] r_seen;

    assign w_idx = minterm_idx(x1, x2, x3);
    assign f     = TRUTH_TABLE[w_idx];

    // Clear wins over recording the current minterm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_q  <= RESET_F;
            r_seen <= '0;
        end else begin
            r_f_q <= f;
            if (clr_seen) begin
                r_seen <= '0;
            end else begin
                r_seen <= r_seen | (N_MINTERMS'(1) << w_idx);
            end
        end
    end

    assign f_q      = r_f_q;
    assign seen     = r_seen;
    assign all_seen = (r_seen == {N_MINTERMS{1'b1}});

endmodule

// File: tb/tb_tamrin_3.sv
// Scoreboard bench for tamrin_3: driver pushes expected outputs from a
// behavioural model, a monitor pops and compares on each sample strobe.
module tb_tamrin_3;

    logic       clk      = 1'b0;
    logic       clk_en   = 1'b0;
    logic       rst_n    = 1'b1;
    logic       x1       = 1'b0;
    logic       x2       = 1'b0;
    logic       x3       = 1'b0;
    logic       clr_seen = 1'b0;
    logic       f;
    logic       f_q;
    logic [7:0] seen;
    logic       all_seen;

    tamrin_3 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x1       (x1),
        .x2       (x2),
        .x3       (x3),
        .clr_seen (clr_seen),
        .f        (f),
        .f_q      (f_q),
        .seen     (seen),
        .all_seen (all_seen)
    );

    always #5 if (clk_en) clk = ~clk;

    typedef struct {
        string      nm;
        logic       f;
        logic       fq;
        logic [7:0] seen;
        logic       all;
    } exp_t;

    exp_t q[$];
    event ev_strobe;
    int   errors = 0;
    int   checks = 0;

    // Behavioural model: mux function plus a set of covered minterms.
    logic       m_fq;
    bit         m_cov[8];
    logic [2:0] cur_x   = 3'd0;
    logic       cur_clr = 1'b0;

    function automatic logic f_model(input logic [2:0] x);
        return x[2] ? x[1] : x[0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_cov[i] = 1'b0;
    endtask

    task automatic push(input string nm);
        exp_t e;
        e.nm   = nm;
        e.f    = f_model(cur_x);
        e.fq   = m_fq;
        e.all  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e.seen[i] = m_cov[i];
            if (!m_cov[i]) e.all = 1'b0;
        end
        q.push_back(e);
    endtask

    task automatic check(input string nm, input string what, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s: got %h want %h at %0t", nm, what, got, want, $time);
        end
    endtask

    always @(negedge clk) -> ev_strobe;

    initial begin
        exp_t e;
        forever begin
            @(ev_strobe);
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.nm, "f",        8'(f),        8'(e.f));
                check(e.nm, "f_q",      8'(f_q),      8'(e.fq));
                check(e.nm, "seen",     seen,         e.seen);
                check(e.nm, "all_seen", 8'(all_seen), 8'(e.all));
            end
        end
    end

    // Unclocked vector: inputs settle, strobe mid-window.
    task automatic comb_vec(input logic [2:0] x, input string nm);
        {x1, x2, x3} = x;
        cur_x = x;
        push(nm);
        #50;
        -> ev_strobe;
        #50;
    endtask

    // One clocked cycle: model the edge, then drive the next inputs.
    task automatic step(input logic [2:0] x, input logic clr, input logic rst, input string nm);
        @(posedge clk);
        if (rst_n) begin
            m_fq = f_model(cur_x);
            if (cur_clr) model_clear();
            else         m_cov[cur_x] = 1'b1;
        end
        #1;
        {x1, x2, x3} = x;
        clr_seen = clr;
        rst_n    = rst;
        cur_x    = x;
        cur_clr  = clr;
        if (!rst) begin
            m_fq = 1'b0;
            model_clear();
        end
        push(nm);
    endtask

    initial begin
        m_fq = 1'b0;
        model_clear();
        #1 rst_n = 1'b0;
        #1;

        for (int i = 0; i < 8; i++) comb_vec(3'(i), "sweep");
        for (int i = 0; i < 4; i++) comb_vec(3'($urandom_range(0, 7)), "rst_hold");
        comb_vec(3'b011, "rst_f011");

        clk_en = 1'b1;
        for (int i = 0; i < 3; i++) step(3'($urandom_range(0, 7)), 1'b0, 1'b0, "rst_clk");

        step(3'b000, 1'b0, 1'b1, "release");
        step(3'b110, 1'b0, 1'b1, "reg_110");
        step(3'b100, 1'b0, 1'b1, "reg_100");
        step(3'b100, 1'b1, 1'b1, "pre_clr");
        for (int i = 0; i < 8; i++) step(3'(i), 1'b0, 1'b1, "cover");
        step(3'b101, 1'b1, 1'b1, "clr_pri");
        step(3'b101, 1'b0, 1'b1, "clr_rel");
        step(3'b000, 1'b0, 1'b1, "after_clr");

        for (int i = 0; i < 300; i++)
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0), 1'b1, "random");

        step(3'b010, 1'b1, 1'b1, "mk3c_clr");
        for (int i = 2; i <= 5; i++) step(3'(i), 1'b0, 1'b1, "mk3c");
        step(3'b111, 1'b0, 1'b1, "at_3c");
        step(3'b111, 1'b0, 1'b0, "async_rst");
        step(3'b001, 1'b0, 1'b0, "rst_low");
        step(3'b110, 1'b0, 1'b1, "rerelease");
        for (int i = 0; i < 20; i++)
            step(3'($urandom_range(0, 7)), 1'b0, 1'b1, "tail");

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        check("drain", "queue_left", 8'(q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tamrin_3.md
Name: tamrin_3

Overview:
- Three-input Boolean function block. Primary output f is a purely combinational function of x1, x2 and x3.
- Also provides a registered copy of f and a sticky minterm-coverage record so a surrounding design or bench can confirm that all 8 input combinations were applied.
- Sits as a leaf cell in the lab exercise hierarchy.
- Default function is a 2:1 multiplexer: f = x1·x2 + x1'·x3.

Parameters:
- TRUTH_TABLE, 8'hCA, output value per minterm. Bit index is {x1,x2,x3}; x1 is the MSB of the index.
- RESET_F, 1'b0, reset value of f_q.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- x1  input  1  function input, MSB of the minterm index.
- x2  input  1  function input.
- x3  input  1  function input, LSB of the minterm index.
- f  output  1  combinational result: TRUTH_TABLE[{x1,x2,x3}].
- f_q  output  1  f registered on the rising clk edge.
- seen  output  8  sticky coverage; bit i is set once minterm i has been sampled.
- all_seen  output  1  high when seen == 8'hFF.
- clr_seen  input  1  synchronous clear of seen.

Behaviour:
- Interface decision: one clock (clk); reset rst_n is asynchronous and active-low.
- f is combinational, with zero clock latency. It is independent of clk and rst_n, so it is valid even while rst_n is low.
- Default truth table, index {x1,x2,x3} -> f: 000->0, 001->1, 010->0, 011->1, 100->0, 101->0, 110->1, 111->1.
- Reset: when rst_n goes low, f_q = RESET_F, seen = 8'h00 and all_seen = 0, immediately and without waiting for a clock edge. These values hold while rst_n is low.
- f_q: on each rising clk edge with rst_n high, f_q <= f. Latency is one cycle.
- seen update, on each rising clk edge with rst_n high:
  - if clr_seen = 1: seen <= 8'h00. Clear takes priority, and the current minterm is not recorded that cycle.
  - else: seen <= seen | (8'h01 << {x1,x2,x3}).
- all_seen is combinational from the seen register, so it asserts in the same cycle seen reaches 8'hFF.
- X/Z on any input propagates to f; no masking is performed.
- Reset released mid-operation: the first rising edge after deassertion samples normally. There is no synchronizer inside the block; deassertion timing is the integrator's responsibility.

Decomposition:
- Shared package: default truth-table constant TAMRIN3_TT_DEFAULT = 8'hCA, and a minterm-index typedef (3-bit logic).
- No sub-module is needed. The combinational lookup is a single expression; the coverage register and f_q share one always block.

Test Plan:
- Exhaustive combinational sweep: apply {x1,x2,x3} = 000..111 with 100 ns spacing and no clock -> f = 0,1,0,1,0,0,1,1.
- Reset: hold rst_n = 0 with random inputs -> f_q = 0, seen = 00, all_seen = 0. Meanwhile f still tracks the inputs, e.g. 011 -> f = 1.
- Registered path: after reset release, apply 110 before edge n -> f_q = 1 after edge n. Then apply 100 -> f_q = 0 after edge n+1.
- Coverage: clock through all 8 minterms in order -> seen = 01, 03, 07, ... FF; all_seen rises on the 8th edge.
- Clear priority: with seen = FF, assert clr_seen while input = 101 -> seen = 00 after the edge. Deassert clr_seen -> seen = 20 after the next edge.
- Async reset mid-run: drop rst_n between edges with seen = 3C -> seen = 00 and f_q = 0 immediately, with no edge required.
